// File: rtl/apb2axi_rd_collector.sv
// AXI R-channel collector: forwards tagged read beats to the RDF and emits one completion per burst.
// Optional statistics counters are enabled by defining APB2AXI_RDC_STATS_EN.
package apb2axi_pkg;
    localparam int unsigned TAG_NUM       = 16;
    localparam int unsigned MAX_BEATS_NUM = 16;
    localparam int unsigned AXI_ID_W      = 4;
    localparam int unsigned AXI_DATA_W    = 64;
    localparam int unsigned TAG_W         = $clog2(TAG_NUM);
    localparam int unsigned CNT_W         = 8;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
        logic [1:0]            resp;
    } rdf_entry_t;

    typedef struct packed {
        logic             is_write;
        logic [TAG_W-1:0] tag;
        logic [1:0]       resp;
        logic             error;
        logic [CNT_W-1:0] num_beats;
    } completion_entry_t;

    localparam int unsigned RDF_W        = $bits(rdf_entry_t);
    localparam int unsigned COMPLETION_W = $bits(completion_entry_t);
endpackage

module apb2axi_rd_collector
    import apb2axi_pkg::*;
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [AXI_ID_W-1:0]     rid,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    rdf_valid,
    output logic [RDF_W-1:0]        rdf_data,
    input  logic                    rdf_ready,
    output logic                    cpl_valid,
    output logic [COMPLETION_W-1:0] cpl_data,
    input  logic                    cpl_ready,
    output logic                    proto_err
`ifdef APB2AXI_RDC_STATS_EN
    ,
    output logic [31:0]             stat_beats,
    output logic [31:0]             stat_bursts,
    output logic [15:0]             stat_errs
`endif
);

    logic [CNT_W-1:0] cnt_q   [TAG_NUM];
    logic [1:0]       wresp_q [TAG_NUM];
    logic             err_q   [TAG_NUM];

    logic              rdf_valid_q, cpl_valid_q, proto_err_q;
    rdf_entry_t        rdf_q, rdf_d;
    completion_entry_t cpl_q, cpl_d;

    logic             accept_c;
    logic [TAG_W-1:0] tag_c;
    logic [CNT_W-1:0] cur_cnt_c, cnt_d;
    logic [1:0]       wresp_d;
    logic             err_d;
    logic             overflow_c;

    // Both output slots must be able to take a beat so an rlast beat is never half-pushed.
    assign rready   = (!rdf_valid_q | rdf_ready) & (!cpl_valid_q | cpl_ready) & aresetn;
    assign accept_c = rvalid & rready;
    assign tag_c    = rid[TAG_W-1:0];

    assign cur_cnt_c  = cnt_q[tag_c];
    assign overflow_c = accept_c & !rlast & (cur_cnt_c == CNT_W'(MAX_BEATS_NUM - 1));
    assign cnt_d      = overflow_c ? cur_cnt_c : cur_cnt_c + CNT_W'(1);
    assign wresp_d    = (rresp > wresp_q[tag_c]) ? rresp : wresp_q[tag_c];
    assign err_d      = err_q[tag_c] | rresp[1];

    always_comb begin
        rdf_d           = '0;
        rdf_d.tag       = tag_c;
        rdf_d.data      = rdata;
        rdf_d.last      = rlast;
        rdf_d.resp      = rresp;
        cpl_d           = '0;
        cpl_d.is_write  = 1'b0;
        cpl_d.tag       = tag_c;
        cpl_d.resp      = wresp_d;
        cpl_d.error     = err_d;
        cpl_d.num_beats = cur_cnt_c + CNT_W'(1);
    end

    // Per-tag burst tracking; an rlast beat retires the tag's state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < TAG_NUM; i++) begin
                cnt_q[i]   <= '0;
                wresp_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else if (accept_c) begin
            if (rlast) begin
                cnt_q[tag_c]   <= '0;
                wresp_q[tag_c] <= '0;
                err_q[tag_c]   <= 1'b0;
            end else begin
                cnt_q[tag_c]   <= cnt_d;
                wresp_q[tag_c] <= wresp_d;
                err_q[tag_c]   <= err_d | overflow_c;
            end
        end
    end

    // Output stages reload on the same edge they are popped, giving one beat per clock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdf_valid_q <= 1'b0;
            rdf_q       <= '0;
            cpl_valid_q <= 1'b0;
            cpl_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (accept_c) begin
                rdf_valid_q <= 1'b1;
                rdf_q       <= rdf_d;
            end else if (rdf_ready) begin
                rdf_valid_q <= 1'b0;
            end
            if (accept_c && rlast) begin
                cpl_valid_q <= 1'b1;
                cpl_q       <= cpl_d;
            end else if (cpl_ready) begin
                cpl_valid_q <= 1'b0;
            end
            if (overflow_c) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign rdf_valid = rdf_valid_q;
    assign rdf_data  = rdf_q;
    assign cpl_valid = cpl_valid_q;
    assign cpl_data  = cpl_q;
    assign proto_err = proto_err_q;

`ifdef APB2AXI_RDC_STATS_EN
    logic [31:0] stat_beats_q, stat_bursts_q;
    logic [15:0] stat_errs_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_beats_q  <= '0;
            stat_bursts_q <= '0;
            stat_errs_q   <= '0;
        end else if (accept_c) begin
            stat_beats_q <= stat_beats_q + 32'd1;
            if (rlast) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
                if (err_d) begin
                    stat_errs_q <= stat_errs_q + 16'd1;
                end
            end
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_bursts = stat_bursts_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_apb2axi_rd_collector.sv
// Bench for apb2axi_rd_collector: vector table, directed corner sequences and randomized traffic vs. a burst-level model.
module tb_apb2axi_rd_collector;
    import apb2axi_pkg::*;

    logic                    aclk = 1'b0;
    logic                    aresetn;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast, rvalid, rready;
    logic                    rdf_valid, rdf_ready;
    logic [RDF_W-1:0]        rdf_data;
    logic                    cpl_valid, cpl_ready;
    logic [COMPLETION_W-1:0] cpl_data;
    logic                    proto_err;
`ifdef APB2AXI_RDC_STATS_EN
    logic [31:0] stat_beats, stat_bursts;
    logic [15:0] stat_errs;
`endif

    apb2axi_rd_collector dut (
        .aclk(aclk), .aresetn(aresetn), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rdf_valid(rdf_valid), .rdf_data(rdf_data), .rdf_ready(rdf_ready),
        .cpl_valid(cpl_valid), .cpl_data(cpl_data), .cpl_ready(cpl_ready),
        .proto_err(proto_err)
`ifdef APB2AXI_RDC_STATS_EN
        , .stat_beats(stat_beats), .stat_bursts(stat_bursts), .stat_errs(stat_errs)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Burst-level reference: counts beats per tag, no notion of registers or saturation logic.
    rdf_entry_t        q_rdf[$];
    completion_entry_t q_cpl[$];
    int                nonlast[TAG_NUM];
    logic [1:0]        mresp[TAG_NUM];
    bit                merr[TAG_NUM];
    bit                mproto;
    bit                acc;

    typedef struct {
        logic [3:0] id;
        logic [1:0] rs;
        logic       last;
        logic       exp_cpl;
        logic [1:0] exp_resp;
        logic       exp_err;
        logic [7:0] exp_nb;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        q_rdf.delete();
        q_cpl.delete();
        mproto = 1'b0;
        for (int i = 0; i < TAG_NUM; i++) begin
            nonlast[i] = 0; mresp[i] = 2'b00; merr[i] = 1'b0;
        end
    endtask

    task automatic model_accept();
        int t;
        int total;
        rdf_entry_t        e;
        completion_entry_t c;
        t = int'(rid);
        e.tag = rid; e.data = rdata; e.last = rlast; e.resp = rresp;
        q_rdf.push_back(e);
        if (rresp > mresp[t]) mresp[t] = rresp;
        merr[t] = merr[t] | rresp[1];
        if (!rlast) begin
            nonlast[t]++;
            if (nonlast[t] >= MAX_BEATS_NUM) begin
                merr[t] = 1'b1;
                mproto  = 1'b1;
            end
        end else begin
            total = nonlast[t] + 1;
            if (total > MAX_BEATS_NUM) total = MAX_BEATS_NUM;
            c.is_write = 1'b0; c.tag = rid; c.resp = mresp[t];
            c.error = merr[t]; c.num_beats = 8'(total);
            q_cpl.push_back(c);
            nonlast[t] = 0; mresp[t] = 2'b00; merr[t] = 1'b0;
        end
    endtask

    // One clock: check outputs against the model at negedge, advance model, return at posedge+1.
    task automatic cycle();
        bit exp_rready;
        @(negedge aclk);
        exp_rready = (q_rdf.size() == 0 || rdf_ready) && (q_cpl.size() == 0 || cpl_ready);
        chk("rdf_valid", rdf_valid, q_rdf.size() != 0);
        if (q_rdf.size() != 0) chk("rdf_data", rdf_data, q_rdf[0]);
        chk("cpl_valid", cpl_valid, q_cpl.size() != 0);
        if (q_cpl.size() != 0) chk("cpl_data", cpl_data, q_cpl[0]);
        chk("rready", rready, exp_rready);
        chk("proto_err", proto_err, mproto);
        if (q_rdf.size() != 0 && rdf_ready) void'(q_rdf.pop_front());
        if (q_cpl.size() != 0 && cpl_ready) void'(q_cpl.pop_front());
        acc = rvalid && exp_rready;
        if (acc) model_accept();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [3:0] id, input logic [1:0] rs, input logic last);
        rid = id; rresp = rs; rlast = last; rdata = {$urandom, $urandom}; rvalid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            cycle();
            if (acc) break;
            if (n == 63) chk("send_timeout", 1, 0);
        end
        rvalid = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        aresetn = 1'b0;
        #2;
        chk({nm, "_rdf_valid"}, rdf_valid, 0);
        chk({nm, "_rdf_data"}, rdf_data, 0);
        chk({nm, "_cpl_valid"}, cpl_valid, 0);
        chk({nm, "_cpl_data"}, cpl_data, 0);
        chk({nm, "_proto"}, proto_err, 0);
        chk({nm, "_rready"}, rready, 0);
        model_clear();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    logic [RDF_W-1:0] held;

    initial begin
        vecs[0]  = '{4'd3, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[1]  = '{4'd3, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[2]  = '{4'd3, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[3]  = '{4'd3, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'd4};
        vecs[4]  = '{4'd1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[5]  = '{4'd2, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[6]  = '{4'd1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'd2};
        vecs[7]  = '{4'd2, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'd2};
        vecs[8]  = '{4'd5, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[9]  = '{4'd5, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
        vecs[10] = '{4'd5, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 8'd3};
        vecs[11] = '{4'd9, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1};
        vecs[12] = '{4'd9, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'd1};

        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        rdf_ready = 1'b1; cpl_ready = 1'b1;
        model_clear();
        do_reset("rst0");

        // Table: bursts, interleave and error response, with both sinks always ready.
        foreach (vecs[i]) begin
            send(vecs[i].id, vecs[i].rs, vecs[i].last);
            chk("tbl_rdf_tag", rdf_data[70:67], vecs[i].id);
            chk("tbl_rdf_last", rdf_data[2], vecs[i].last);
            chk("tbl_rdf_resp", rdf_data[1:0], vecs[i].rs);
            chk("tbl_cpl_valid", cpl_valid, vecs[i].exp_cpl);
            if (vecs[i].exp_cpl)
                chk("tbl_cpl", cpl_data, {1'b0, vecs[i].id, vecs[i].exp_resp, vecs[i].exp_err, vecs[i].exp_nb});
        end

        // RDF back-pressure: the held beat must stay put and the next beat must wait.
        send(4'd4, 2'b00, 1'b0);
        rdf_ready = 1'b0;
        held = rdf_data;
        rid = 4'd4; rresp = 2'b00; rlast = 1'b0; rdata = {$urandom, $urandom}; rvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("stall_rready", rready, 0);
            chk("stall_hold", rdf_data, held);
        end
        rdf_ready = 1'b1;
        for (int n = 0; n < 8 && !acc; n++) cycle();
        rvalid = 1'b0;
        send(4'd4, 2'b00, 1'b1);
        chk("stall_cpl", cpl_data, {1'b0, 4'd4, 2'b00, 1'b0, 8'd3});
        cycle();

        // Overlong burst on tag 0: 17 non-last beats, then rlast.
        for (int n = 0; n < 17; n++) begin
            send(4'd0, 2'b00, 1'b0);
            if (n == 14) chk("ovf_proto_before", proto_err, 0);
            if (n >= 15) chk("ovf_proto_after", proto_err, 1);
        end
        send(4'd0, 2'b00, 1'b1);
        chk("ovf_cpl", cpl_data, {1'b0, 4'd0, 2'b00, 1'b1, 8'd16});
        chk("ovf_proto_sticky", proto_err, 1);
        cycle();

        // Reset in the middle of a tag-7 burst with a beat still pending.
        send(4'd7, 2'b00, 1'b0);
        send(4'd7, 2'b00, 1'b0);
        do_reset("rst_mid");
        send(4'd7, 2'b00, 1'b1);
        chk("rst_mid_cpl", cpl_data, {1'b0, 4'd7, 2'b00, 1'b0, 8'd1});
        cycle();

        // Randomized interleaved traffic with random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            rvalid    = ($urandom_range(99) < 70);
            rid       = 4'($urandom_range(3) + (($urandom_range(9) == 0) ? 8 : 0));
            rresp     = 2'($urandom);
            rlast     = ($urandom_range(99) < 25);
            rdata     = {$urandom, $urandom};
            rdf_ready = ($urandom_range(99) < 75);
            cpl_ready = ($urandom_range(99) < 75);
            cycle();
        end

        rvalid = 1'b0; rdf_ready = 1'b1; cpl_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        chk("drain_rdf", q_rdf.size(), 0);
        chk("drain_cpl", q_cpl.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
